// File: rtl/hoene_sel_pkg.sv
// Shared types and helpers for the multi-input selector.
// State encoding, select-width function, lowest-set-bit pick.
package hoene_sel_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int lowest_set(
    input logic [31:0] v
  );
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/hoene_edge_counter.sv
// Per-channel synchroniser, rising-edge detect and
// saturating edge counter with clear and freeze.
module hoene_edge_counter
  import hoene_sel_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int THRESH      = 63,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clear,
  input  logic freeze,
  output logic sync,
  output logic rise,
  output logic hit
);

  localparam logic [CNT_W-1:0] TH =
    CNT_W'(THRESH);

  logic [SYNC_STAGES-1:0] sq;
  logic                   prev;
  logic [CNT_W-1:0]       cnt;

  assign sync = sq[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign hit  = (cnt == TH);

  // Synchroniser chain plus delayed copy for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq   <= '0;
      prev <= 1'b0;
    end else begin
      sq   <= {sq[SYNC_STAGES-2:0], din};
      prev <= sq[SYNC_STAGES-1];
    end
  end

  // Saturating edge count; clear drops same-cycle edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (!freeze && rise && !hit)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hoene_multi_input_selector.sv
// Activity-based N-input selector: locks first busy channel.
// Optional lock-loss watchdog with `LOSS_DETECT_EN.
module hoene_multi_input_selector
  import hoene_sel_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 6,
  parameter int THRESH      = 2**CNT_W-1,
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_CH  = 0,
  parameter int TIMEOUT_W   = 8,
  localparam int SEL_W      = sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in,
  input  logic              clear,
  input  logic              test_force,
  input  logic [SEL_W-1:0]  test_sel,
  output logic              out,
  output logic [SEL_W-1:0]  sel,
  output logic              locked,
  output logic              lost
);

  localparam logic [SEL_W-1:0] DEF =
    SEL_W'(DEFAULT_CH);
  localparam logic [SEL_W-1:0] MAXC =
    SEL_W'(NUM_CH-1);

  state_t              state;
  state_t              ns;
  logic [SEL_W-1:0]    lock_ch;
  logic [SEL_W-1:0]    tsel;
  logic [SEL_W-1:0]    eff;
  logic [NUM_CH-1:0]   sync;
  logic [NUM_CH-1:0]   rise;
  logic [NUM_CH-1:0]   hit;
  logic                loss_evt;
  logic                cnt_clr;
  logic                frz;

  assign frz     = (state == LOCKED);
  assign cnt_clr = clear | loss_evt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hoene_edge_counter #(
      .CNT_W       (CNT_W),
      .THRESH      (THRESH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ec (
      .clk    (clk),
      .rst    (rst),
      .din    (in[g]),
      .clear  (cnt_clr),
      .freeze (frz),
      .sync   (sync[g]),
      .rise   (rise[g]),
      .hit    (hit[g])
    );
  end

`ifdef LOSS_DETECT_EN
  logic [TIMEOUT_W-1:0] wd;

  assign loss_evt = (state == LOCKED) && (&wd);

  // Idle-cycle watchdog on the locked channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd <= '0;
    else if (state != LOCKED || ns != LOCKED)
      wd <= '0;
    else if (rise[lock_ch])
      wd <= '0;
    else if (!(&wd))
      wd <= wd + 1'b1;
  end
`else
  assign loss_evt = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= ns;
  end

  // Next state: clear beats a same-cycle lock
  always_comb begin
    ns = state;
    unique case (state)
      SEARCH: if (!clear && (|hit)) ns = LOCKED;
      LOCKED: if (cnt_clr)          ns = SEARCH;
      default:                      ns = SEARCH;
    endcase
  end

  // FSM outputs
  always_comb begin
    locked = (state == LOCKED);
    lost   = loss_evt;
  end

  // Capture lowest-index hit on entering LOCKED
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lock_ch <= DEF;
    else if (state == SEARCH && ns == LOCKED)
      lock_ch <= SEL_W'(lowest_set(32'(hit)));
  end

  // Effective route with override clamp
  always_comb begin
    tsel = (test_sel > MAXC) ? MAXC : test_sel;
    if (test_force)     eff = tsel;
    else if (frz)       eff = lock_ch;
    else                eff = DEF;
  end

  // Registered routing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= 1'b0;
      sel <= DEF;
    end else begin
      out <= sync[eff];
      sel <= eff;
    end
  end

endmodule
